// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, bit shifting on device clock, ACK check.
// Optional build macro PS2_TX_RETRY_EN: one automatic retransmission before reporting an error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 5000,
  parameter int START_HOLD_CYCLES = 50,
  parameter int TIMEOUT_CYCLES    = 750000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state      | meaning
  // IDLE       | lines released, waiting for send
  // INHIBIT    | clock held low to claim the bus
  // START      | clock and data held low (start bit)
  // SHIFT      | clock released, data/parity/stop driven on device falling edges
  // ACK        | sample device ACK level
  // WAIT_IDLE  | wait for clock and data both high, then report
  // RETRY_WAIT | lines released before a retransmission
  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, RETRY_WAIT
  } state_t;

  localparam int PHASE_MAX = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] INH_LOAD  = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LOAD = PW'(START_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic          clk_fall;
  logic [7:0]    byte_q, byte_nxt;
  logic [9:0]    shreg, shreg_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic [PW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          nack, nack_nxt;
  logic          clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, error_nxt;
  logic          fail, tmo_run;
`ifdef PS2_TX_RETRY_EN
  logic          retried, retried_nxt;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign clk_fall = clk_prev & ~clk_s2;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      byte_q      <= '0;
      shreg       <= '1;
      bit_cnt     <= '0;
      cnt         <= '0;
      tmo         <= '0;
      nack        <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
      byte_q      <= byte_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_nxt;
      cnt         <= cnt_nxt;
      tmo         <= tmo_nxt;
      nack        <= nack_nxt;
`ifdef PS2_TX_RETRY_EN
      retried     <= retried_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    clk_oe_nxt  = ps2_clk_oe;
    data_oe_nxt = ps2_data_oe;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;
    byte_nxt    = byte_q;
    shreg_nxt   = shreg;
    bit_nxt     = bit_cnt;
    cnt_nxt     = cnt;
    tmo_nxt     = tmo;
    nack_nxt    = nack;
    fail        = 1'b0;
    tmo_run     = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
`ifdef PS2_TX_RETRY_EN
    retried_nxt = retried;
`endif

    case (state)
      IDLE: begin
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = 1'b0;
        if (send) begin
          byte_nxt   = tx_data;
          clk_oe_nxt = 1'b1;
          busy_nxt   = 1'b1;
          cnt_nxt    = INH_LOAD;
          state_nxt  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retried_nxt = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt == '0) begin
          data_oe_nxt = 1'b1;
          cnt_nxt     = HOLD_LOAD;
          state_nxt   = START;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      START: begin
        if (cnt == '0) begin
          clk_oe_nxt = 1'b0;
          shreg_nxt  = {1'b1, ~^byte_q, byte_q};
          bit_nxt    = '0;
          tmo_nxt    = '0;
          state_nxt  = SHIFT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SHIFT: begin
        tmo_nxt = tmo + TW'(1);
        if (clk_fall) begin
          if (bit_cnt == 4'd10) begin
            state_nxt = ACK;
          end else begin
            // LSB leaves first; ones refill so the line idles released
            data_oe_nxt = ~shreg[0];
            shreg_nxt   = {1'b1, shreg[9:1]};
            bit_nxt     = bit_cnt + 4'd1;
          end
        end
      end
      ACK: begin
        tmo_nxt   = tmo + TW'(1);
        nack_nxt  = data_s2;
        state_nxt = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        tmo_nxt = tmo + TW'(1);
        if (clk_s2 && data_s2) begin
          if (nack) begin
            fail = 1'b1;
          end else begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      RETRY_WAIT: begin
        if (cnt == '0) begin
          clk_oe_nxt = 1'b1;
          cnt_nxt    = INH_LOAD;
          state_nxt  = INHIBIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // timeout outranks any falling edge seen in the same cycle
    if (tmo_run && (tmo == TMO_LAST)) fail = 1'b1;

    if (fail) begin
      clk_oe_nxt  = 1'b0;
      data_oe_nxt = 1'b0;
      done_nxt    = 1'b0;
      tmo_nxt     = '0;
      bit_nxt     = '0;
      shreg_nxt   = '1;
`ifdef PS2_TX_RETRY_EN
      if (!retried) begin
        retried_nxt = 1'b1;
        cnt_nxt     = INH_LOAD;
        state_nxt   = RETRY_WAIT;
      end else begin
        error_nxt = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
`else
      error_nxt = 1'b1;
      busy_nxt  = 1'b0;
      state_nxt = IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of command bytes against a PS/2 device model,
// plus hand-written timeout, mid-frame send and mid-frame reset sequences.
module tb_ps2_host_tx;
  localparam int INH  = 100;
  localparam int HOLD = 5;
  localparam int TMO  = 20000;
  localparam int HALF = 100;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, error;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .send(send),
    .tx_data(tx_data),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    bit         ack;
    logic       par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_bad = 0;

  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, pulse_busy_bad = 0;
  logic busy_prev = 1'b0;

  // pulse bookkeeping: busy must drop in the very cycle done/error shows
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    if ((done || error) && !(busy_prev && !busy)) pulse_busy_bad++;
    busy_prev = busy;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_send(input logic [7:0] d);
    @(negedge clock);
    tx_data = d;
    send    = 1'b1;
    @(negedge clock);
    send    = 1'b0;
  endtask

  // counts cycles of clock-only hold, then of clock+data hold; returns on the first SHIFT sample
  task automatic measure_start(output int inh, output int hold);
    int g;
    inh = 0; hold = 0; g = 0;
    while (ps2_clk_oe && !ps2_data_oe && g < 1000) begin
      inh++; g++; @(negedge clock);
    end
    while (ps2_clk_oe && ps2_data_oe && g < 1000) begin
      hold++; g++; @(negedge clock);
    end
  endtask

  task automatic wait_clk_oe(output int n);
    n = 0;
    while (!ps2_clk_oe && n < TMO + 1000) begin
      @(negedge clock); n++;
    end
  endtask

  // bits[0]=start level, [8:1]=data, [9]=parity, [10]=stop, each taken at the device rising edge
  task automatic dev_frame(input bit ack, input int nclk, output logic [10:0] bits);
    bits = '0;
    repeat (50) @(negedge clock);
    bits[0] = ps2_data_in;
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clock);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      if (i < 10) bits[i+1] = ps2_data_in;
      dev_clk = 1'b1;
      if (i == 10) dev_data_low = 1'b0;
      repeat (HALF) @(negedge clock);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int g;
    g = 0;
    while (busy && g < 5000) begin
      @(negedge clock); g++;
    end
    ok = !busy;
  endtask

  task automatic chk_bits(input logic [10:0] bits, input logic [7:0] d, input logic par);
    chk("start_bit", bits[0], 1'b0);
    chk("data_byte", bits[8:1], d);
    chk("parity_bit", bits[9], par);
    chk("stop_bit", bits[10], 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0, inh, hold;
    logic [10:0] bits;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    do_send(v.d);
    chk("busy_after_send", busy, 1'b1);
    measure_start(inh, hold);
    chk("inhibit_len", inh, INH);
    chk("start_hold", hold, HOLD);
    dev_frame(v.ack, 11, bits);
    chk_bits(bits, v.d, v.par);
`ifdef PS2_TX_RETRY_EN
    if (!v.ack) begin
      int n;
      wait_clk_oe(n);
      chk("retry_busy_held", busy, 1'b1);
      measure_start(inh, hold);
      chk("retry_inhibit_len", inh, INH);
      dev_frame(v.ack, 11, bits);
      chk_bits(bits, v.d, v.par);
    end
`endif
    wait_idle(ok);
    chk("busy_release", ok, 1'b1);
    chk("done_pulses", done_cnt - d0, v.exp_done);
    chk("error_pulses", err_cnt - e0, v.exp_err);
  endtask

  initial begin
    int inh, hold, n, d0, e0;
    logic [10:0] bits;
    bit ok;

    vecs[0] = '{d: 8'hED, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};
    vecs[1] = '{d: 8'h01, ack: 1'b1, par: 1'b0, exp_done: 1, exp_err: 0};
    vecs[2] = '{d: 8'hFF, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};
    vecs[3] = '{d: 8'hA5, ack: 1'b0, par: 1'b1, exp_done: 0, exp_err: 1};
    vecs[4] = '{d: 8'h00, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};

    #1 resetn = 1'b0;
    #1;
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_data_oe", ps2_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    repeat (5) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // device never clocks: error lands TMO cycles after SHIFT entry
    d0 = done_cnt; e0 = err_cnt;
    do_send(8'h3C);
    measure_start(inh, hold);
`ifdef PS2_TX_RETRY_EN
    wait_clk_oe(n);
    chk("tmo_retry_restart", n, TMO + INH);
    chk("tmo_first_no_error", err_cnt - e0, 0);
    measure_start(inh, hold);
`endif
    n = 0;
    while (!error && n < TMO + 1000) begin
      @(negedge clock); n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("tmo_clk_oe", ps2_clk_oe, 1'b0);
    chk("tmo_data_oe", ps2_data_oe, 1'b0);
    chk("tmo_busy", busy, 1'b0);
    repeat (5) @(negedge clock);
    chk("tmo_error_pulses", err_cnt - e0, 1);
    chk("tmo_done_pulses", done_cnt - d0, 0);

    // second send mid-frame must not disturb the latched byte
    d0 = done_cnt; e0 = err_cnt;
    do_send(8'hED);
    measure_start(inh, hold);
    fork
      dev_frame(1'b1, 11, bits);
      begin
        repeat (400) @(negedge clock);
        tx_data = 8'h55;
        send    = 1'b1;
        @(negedge clock);
        send    = 1'b0;
      end
    join
    chk_bits(bits, 8'hED, 1'b1);
    wait_idle(ok);
    chk("midsend_idle", ok, 1'b1);
    chk("midsend_done", done_cnt - d0, 1);
    chk("midsend_error", err_cnt - e0, 0);

    // asynchronous reset while bit 4 (a 0 in 0xED) is on the line
    d0 = done_cnt; e0 = err_cnt;
    do_send(8'hED);
    measure_start(inh, hold);
    dev_frame(1'b1, 5, bits);
    chk("pre_reset_data_oe", ps2_data_oe, 1'b1);
    chk("pre_reset_busy", busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_clk_oe", ps2_clk_oe, 1'b0);
    chk("arst_data_oe", ps2_data_oe, 1'b0);
    chk("arst_busy", busy, 1'b0);
    repeat (20) @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_no_error", err_cnt - e0, 0);
    run_vec(vecs[1]);

    chk("busy_fall_with_pulse", pulse_busy_bad, 0);
    chk("done_and_error", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
